// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2^2 FFT pipeline: sizing helper, bit reversal
// and the complex sample layout.
package fft_pkg;

  localparam int unsigned DefaultN     = 64;
  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned LOGN         = $clog2(DefaultN);

  typedef struct packed {
    logic [DefaultWidth-1:0] re;
    logic [DefaultWidth-1:0] im;
  } cplx_t;

  function automatic int unsigned logn(input int unsigned n);
    return $clog2(n);
  endfunction

  // Reverses the low nbits of value; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(nbits)) r[int'(nbits) - 1 - i] = value[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// The read register only updates on a read, so it holds between reads.
module reorder_ram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned DW    = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: captures bit-reversed frames into one bank while the
// previous frame streams out of the other bank in natural order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             enable_out,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);

  localparam int unsigned LogN = logn(N);

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } sample_t;

  // Input capture stage; together with the RAM read register it gives N+1 latency.
  logic            in_vld_q;
  sample_t         in_q;
  logic [LogN-1:0] wr_cnt_q, wr_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic [LogN-1:0] rd_cnt_q, rd_cnt_d;
  logic            rd_active_q, rd_active_d;
  logic            enable_out_q;
  logic            have_data_q;
  logic            wr_last;
  logic            rd_last;
  logic [LogN-1:0] wr_cnt_rev;
  logic [LogN:0]   wr_addr;
  logic [LogN:0]   rd_addr;
  sample_t         rd_data;

  always_comb begin
    wr_last     = in_vld_q && (wr_cnt_q == LogN'(N - 1));
    rd_last     = rd_active_q && (rd_cnt_q == LogN'(N - 1));
    // A gap in enable_in throws away any partial frame.
    wr_cnt_d    = in_vld_q ? wr_cnt_q + LogN'(1) : '0;
    wr_bank_d   = wr_bank_q ^ wr_last;
    rd_cnt_d    = rd_cnt_q;
    rd_active_d = rd_active_q;
    if (wr_last) begin
      rd_active_d = 1'b1;
      rd_cnt_d    = '0;
    end else if (rd_active_q) begin
      rd_cnt_d    = rd_cnt_q + LogN'(1);
      rd_active_d = !rd_last;
    end
    wr_cnt_rev = LogN'(bitrev(32'(wr_cnt_q), LogN));
    wr_addr    = {wr_bank_q, wr_cnt_rev};
    rd_addr    = {~wr_bank_q, rd_cnt_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_vld_q     <= 1'b0;
      in_q         <= '0;
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      rd_active_q  <= 1'b0;
      enable_out_q <= 1'b0;
      have_data_q  <= 1'b0;
    end else begin
      in_vld_q     <= enable_in;
      in_q         <= '{re: in_re, im: in_im};
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_active_q  <= rd_active_d;
      enable_out_q <= rd_active_q;
      have_data_q  <= have_data_q | rd_active_q;
    end
  end

  reorder_ram #(
    .DEPTH(2 * N),
    .DW   (2 * WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (in_vld_q),
    .waddr_i(wr_addr),
    .wdata_i(in_q),
    .re_i   (rd_active_q),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  // The RAM read register is not reset, so outputs read as zero until a frame is read.
  assign enable_out = enable_out_q;
  assign out_re     = have_data_q ? rd_data.re : '0;
  assign out_im     = have_data_q ? rd_data.im : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Checks fft_bitrev_reorder at N=8/WIDTH=8 and N=64/WIDTH=16 against a frame-level
// model: each completed frame is scheduled cycle by cycle in natural order.
module tb_fft_bitrev_reorder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en8, eo8;
  logic [7:0]  re8, im8, or8, oi8;
  logic        en64, eo64;
  logic [15:0] re64, im64, or64, oi64;

  fft_bitrev_reorder #(.N(8), .WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable_in(en8), .in_re(re8), .in_im(im8),
    .enable_out(eo8), .out_re(or8), .out_im(oi8)
  );

  fft_bitrev_reorder #(.N(64), .WIDTH(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .enable_in(en64), .in_re(re64), .in_im(im64),
    .enable_out(eo64), .out_re(or64), .out_im(oi64)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cnt_m[2];
  int          t0_m[2];
  logic [15:0] fr_re[2][64];
  logic [15:0] fr_im[2][64];
  logic [15:0] last_re[2];
  logic [15:0] last_im[2];
  int          eo_cnt[2];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic int rev(input int v, input int nb);
    int r = 0;
    for (int i = 0; i < nb; i++) r = r | (((v >> i) & 1) << (nb - 1 - i));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle into DUT d (0: N=8, 1: N=64); the other DUT idles.
  task automatic drive(input int d, input logic en, input logic [15:0] re, input logic [15:0] im);
    int   n;
    int   lg;
    exp_t e;
    n  = (d == 0) ? 8 : 64;
    lg = (d == 0) ? 3 : 6;
    if (d == 0) begin
      en8 = en; re8 = re[7:0]; im8 = im[7:0]; en64 = 1'b0;
      re  = {8'h00, re[7:0]};
      im  = {8'h00, im[7:0]};
    end else begin
      en64 = en; re64 = re; im64 = im; en8 = 1'b0;
    end
    cnt_m[1 - d] = 0;
    if (en) begin
      if (cnt_m[d] == 0) t0_m[d] = cyc + 1;
      fr_re[d][cnt_m[d]] = re;
      fr_im[d][cnt_m[d]] = im;
      cnt_m[d]++;
      if (cnt_m[d] == n) begin
        for (int k = 0; k < n; k++) begin
          e.cyc = t0_m[d] + n + 1 + k;
          e.re  = fr_re[d][rev(k, lg)];
          e.im  = fr_im[d][rev(k, lg)];
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        cnt_m[d] = 0;
      end
    end else begin
      cnt_m[d] = 0;
    end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en8   = 1'b0;
    en64  = 1'b0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    tick();
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      last_re[d] = '0;
      last_im[d] = '0;
    end
  endtask

  task automatic check(input int d);
    logic        obs_en;
    logic        exp_en;
    logic [15:0] obs_re;
    logic [15:0] obs_im;
    exp_t        e;
    exp_en = 1'b0;
    if (d == 0) begin
      obs_en = eo8; obs_re = {8'h00, or8}; obs_im = {8'h00, oi8};
      if (q0.size() > 0 && q0[0].cyc == cyc) begin exp_en = 1'b1; e = q0.pop_front(); end
    end else begin
      obs_en = eo64; obs_re = or64; obs_im = oi64;
      if (q1.size() > 0 && q1[0].cyc == cyc) begin exp_en = 1'b1; e = q1.pop_front(); end
    end
    // When no sample is due the outputs must hold the previous one.
    if (exp_en) begin
      last_re[d] = e.re;
      last_im[d] = e.im;
    end
    if (obs_en === 1'b1) eo_cnt[d]++;
    nvec++;
    assert (obs_en === exp_en) else begin
      nerr++;
      $error("FAIL enable_out dut%0d cyc %0d: observed %b expected %b", d, cyc, obs_en, exp_en);
    end
    nvec++;
    assert (obs_re === last_re[d]) else begin
      nerr++;
      $error("FAIL out_re dut%0d cyc %0d: observed %h expected %h", d, cyc, obs_re, last_re[d]);
    end
    nvec++;
    assert (obs_im === last_im[d]) else begin
      nerr++;
      $error("FAIL out_im dut%0d cyc %0d: observed %h expected %h", d, cyc, obs_im, last_im[d]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check(0);
      check(1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic [7:0]  v;
    logic [15:0] r;
    logic [15:0] s;
    eo_cnt[0] = 0;
    eo_cnt[1] = 0;
    cnt_m[0]  = 0;
    cnt_m[1]  = 0;
    en8 = 1'b0; re8 = '0; im8 = '0;
    en64 = 1'b0; re64 = '0; im64 = '0;
    rst_n = 1'b0;
    tick();
    do_reset();
    mon_on = 1'b1;

    // Idle after reset: outputs stay at zero.
    idle(100);

    // Single frame, in_im = ~in_re.
    base = eo_cnt[0];
    for (int j = 0; j < 8; j++) begin
      v = 8'(j);
      drive(0, 1'b1, {8'h00, v}, {8'h00, ~v});
    end
    idle(12);
    nvec++;
    assert (eo_cnt[0] - base === 8) else begin
      nerr++;
      $error("FAIL single_frame_count: observed %0d expected 8", eo_cnt[0] - base);
    end

    // Four back-to-back frames.
    base = eo_cnt[0];
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 8; j++) begin
        v = 8'(8 * f + j);
        drive(0, 1'b1, {8'h00, v}, {8'h00, ~v});
      end
    end
    idle(12);
    nvec++;
    assert (eo_cnt[0] - base === 32) else begin
      nerr++;
      $error("FAIL b2b_count: observed %0d expected 32", eo_cnt[0] - base);
    end

    // Partial frame of 5 samples, then a full frame.
    base = eo_cnt[0];
    for (int j = 0; j < 5; j++) drive(0, 1'b1, 16'(200 + j), 16'(50 + j));
    idle(3);
    for (int j = 0; j < 8; j++) drive(0, 1'b1, 16'(100 + j), 16'(150 + j));
    idle(12);
    nvec++;
    assert (eo_cnt[0] - base === 8) else begin
      nerr++;
      $error("FAIL partial_count: observed %0d expected 8", eo_cnt[0] - base);
    end

    // Reset while frame 0 is read and frame 1 is written, then a fresh frame.
    for (int j = 0; j < 8; j++) drive(0, 1'b1, 16'(40 + j), 16'(90 + j));
    for (int j = 0; j < 4; j++) drive(0, 1'b1, 16'(60 + j), 16'(70 + j));
    do_reset();
    base = eo_cnt[0];
    for (int j = 0; j < 8; j++) drive(0, 1'b1, 16'(16 + 3 * j), 16'(240 - j));
    idle(12);
    nvec++;
    assert (eo_cnt[0] - base === 8) else begin
      nerr++;
      $error("FAIL post_reset_count: observed %0d expected 8", eo_cnt[0] - base);
    end

    // N=64: ten random frames with random idle gaps (including none).
    base = eo_cnt[1];
    for (int f = 0; f < 10; f++) begin
      idle($urandom_range(0, 5));
      for (int j = 0; j < 64; j++) begin
        r = 16'($urandom);
        s = 16'($urandom);
        drive(1, 1'b1, r, s);
      end
    end
    idle(80);
    nvec++;
    assert (eo_cnt[1] - base === 640) else begin
      nerr++;
      $error("FAIL n64_count: observed %0d expected 640", eo_cnt[1] - base);
    end

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer placed directly downstream of the last SDF/twiddle stage of the radix-2² pipeline. The SDF chain emits each N-point frame in bit-reversed index order; this block captures each frame into one half of a ping-pong memory at bit-reversed addresses while streaming the previous frame out of the other half in natural order. Continuous back-to-back frames are sustained with no bubbles; a fixed latency of N+1 cycles is added.

## Interface
- `N`, default 64: FFT length in points, power of two, ≥ 4.
- `WIDTH`, default 8: bit width of each real and imaginary component, two's complement.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable_in`  in  1  high for every valid input sample; held high for N consecutive cycles per frame.
- `in_re`  in  WIDTH  real part, bit-reversed frame order.
- `in_im`  in  WIDTH  imaginary part, bit-reversed frame order.
- `enable_out`  out  1  high while `out_re`/`out_im` carry a valid natural-order sample.
- `out_re`  out  WIDTH  real part, natural order.
- `out_im`  out  WIDTH  imaginary part, natural order.

## Operation
- Memory: 2·N words of 2·WIDTH bits, split into bank 0 and bank 1. `wr_bank` selects the bank being written; the read bank is always the other one.
- Write side: `wr_cnt` (log2 N bits) increments on every cycle where `enable_in` is high. The sample is written at address `{wr_bank, bitrev(wr_cnt)}`.
- When a write occurs with `wr_cnt` = N−1, the frame is complete:
  - `wr_bank` toggles.
  - `wr_cnt` wraps to 0.
  - A read of the just-filled bank is armed (`rd_active`←1, `rd_cnt`←0).
- Partial frame: if `enable_in` is low while `wr_cnt` ≠ 0:
  - `wr_cnt` returns to 0 and the partial frame is discarded.
  - `wr_bank` does not toggle and no read is armed.
- Read side: while `rd_active` is high, read address `{~wr_bank, rd_cnt}` and increment `rd_cnt`. When `rd_cnt` = N−1 is read, `rd_active` clears, unless a new frame completes in the same cycle, in which case the read re-arms at 0.
- Frame completion and the last read of the previous frame may coincide. Back-to-back streaming is the normal case; no stall or drop may occur.
- Read data is registered into `out_re`/`out_im`. `enable_out` is `rd_active` delayed by one cycle.
- While `enable_out` is low, `out_re`/`out_im` hold their last value.
- No arithmetic is performed; data passes bit-exact.

## Timing
- Reset values: `enable_out` = 0, `out_re` = 0, `out_im` = 0, `wr_cnt` = 0, `rd_cnt` = 0, `wr_bank` = 0, `rd_active` = 0. Memory contents are not reset.
- Reset mid-operation: the frame being written and the frame being read are both abandoned. `enable_out` falls on the cycle after `rst_n` is sampled low.
- Latency: let the first sample of a frame be accepted at edge t0. Natural-index sample k then appears on the outputs after edge t0+N+1+k, i.e. the first output is valid N+1 cycles after the first input.
- Throughput: one sample per cycle. `enable_out` stays high for exactly N cycles per completed frame. It stays continuously high across back-to-back frames.
- Memory read latency is one cycle, registered inside the RAM sub-module. No output register is added beyond that.

## Structure
- Shared package `fft_pkg`:
  - `localparam` helper `clog2`-based `LOGN`.
  - Function `bitrev(value, nbits)`.
  - Complex sample typedef: `{re, im}`, each WIDTH bits.
- Sub-module `reorder_ram`: simple dual-port RAM, one write port and one read port, synchronous registered read, parameters `DEPTH` and `DW`, no reset.
- The top level contains only counters, bank control and the bit-reversal address mapping.

## Test plan
- N=8, WIDTH=8, one frame with `in_re` = 0..7 in arrival order and `in_im` = ~`in_re` → `out_re` = 0,4,2,6,1,5,3,7 with matching `out_im`. `enable_out` is high for exactly 8 cycles, the first at t0+9.
- N=8, four back-to-back frames, arrival values 8f+j → `enable_out` continuously high for 32 cycles. Every frame is reordered correctly with no gap or duplicate.
- N=8, `enable_in` drops after 5 samples, then a full frame is sent → no output for the partial frame. The full frame is output correctly at t0'+9.
- N=8, `rst_n` low for 1 cycle during the read of frame 0 while frame 1 is being written → `enable_out` = 0 and outputs = 0 on the next cycle. A fresh frame after reset reorders correctly.
- N=64, WIDTH=16, random data over 10 frames with random idle gaps between frames → scoreboard matches the output against the input permuted by 6-bit `bitrev`. `enable_out` count equals 640.
- Idle after reset for 100 cycles → `enable_out`, `out_re` and `out_im` remain 0.
